// File: rtl/layer_sequencer.sv
// layer_sequencer
// Frame-level controller for the CNN inference chain. Each layer engine is
// launched in fixed order with a one-cycle start pulse. The sequencer waits for
// that engine's one-cycle done pulse before it launches the next engine. It also
// provides a frame handshake, abort, a per-stage watchdog, and frame/cycle
// counters for the host-facing status path.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   frame_start  request to run one frame (sampled only when idle)
//   abort        cancel the frame in progress (launch/wait only)
//   stage_start  one-hot, one-cycle start pulse to engine i
//   stage_done   one-cycle done pulse from engine i
//   busy         high whenever the sequencer is not idle
//   cur_stage    index of the stage being launched or awaited
//   frame_done   one-cycle pulse when the last stage completes
//   error        one-cycle pulse on watchdog expiry
//   err_stage    stage that timed out, held until the next error or reset
//   frame_count  frames completed successfully (wraps)
//   last_cycles  launch+wait cycle count of the last successful frame
module layer_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_WIDTH      = 32,
  parameter int IDX_W          = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  abort,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic                  busy,
  output logic [IDX_W-1:0]      cur_stage,
  output logic                  frame_done,
  output logic                  error,
  output logic [IDX_W-1:0]      err_stage,
  output logic [15:0]           frame_count,
  output logic [CNT_WIDTH-1:0]  last_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [CNT_WIDTH-1:0] cycle_cnt;
  logic [CNT_WIDTH-1:0] wdog;

  logic [IDX_W-1:0] idx_next;
  logic             last_stage;
  logic             timeout_hit;

  // Both counters saturate at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign idx_next    = idx + IDX_W'(1);
  assign last_stage  = (idx == IDX_W'(NUM_STAGES - 1));
  // The watchdog is cleared in LAUNCH, so the first WAIT cycle sees 0. Reaching
  // TIMEOUT_CYCLES-1 therefore marks the last permitted WAIT cycle.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (wdog == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  // All outputs are registered. They are set on the edge that enters a state,
  // so every pulse lines up with the state that owns it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      cycle_cnt   <= '0;
      wdog        <= '0;
      stage_start <= '0;
      busy        <= 1'b0;
      cur_stage   <= '0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
      err_stage   <= '0;
      frame_count <= '0;
      last_cycles <= '0;
    end else begin
      stage_start <= '0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            state       <= S_LAUNCH;
            idx         <= '0;
            cycle_cnt   <= '0;
            stage_start <= NUM_STAGES'(1);
            cur_stage   <= '0;
            busy        <= 1'b1;
          end
        end
        S_LAUNCH: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state     <= S_WAIT;
            cycle_cnt <= sat_inc(cycle_cnt);
            wdog      <= '0;
          end
        end
        S_WAIT: begin
          cycle_cnt <= sat_inc(cycle_cnt);
          wdog      <= sat_inc(wdog);
          // Priority: abort, then done, then watchdog expiry.
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (stage_done[idx]) begin
            if (last_stage) begin
              state       <= S_DONE;
              last_cycles <= sat_inc(cycle_cnt);
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
            end else begin
              state       <= S_LAUNCH;
              idx         <= idx_next;
              stage_start <= NUM_STAGES'(1) << idx_next;
              cur_stage   <= idx_next;
            end
          end else if (timeout_hit) begin
            state     <= S_ERR;
            err_stage <= idx;
            error     <= 1'b1;
          end
        end
        S_DONE, S_ERR: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer
// Self-checking bench for layer_sequencer with 3 stages and a 20-cycle watchdog.
// Each frame is described by per-stage engine latencies. The expected outcome
// (success, timeout stage, abort) and the expected cycle total are worked out
// from those latencies before the frame is driven. Inputs are driven and
// outputs sampled on the falling edge.
module tb_layer_sequencer;

  localparam int NS      = 3;
  localparam int TIMEOUT = 20;
  localparam int CW      = 32;
  localparam int IW      = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start;
  logic          abort;
  logic [NS-1:0] stage_start;
  logic [NS-1:0] stage_done;
  logic          busy;
  logic [IW-1:0] cur_stage;
  logic          frame_done;
  logic          error;
  logic [IW-1:0] err_stage;
  logic [15:0]   frame_count;
  logic [CW-1:0] last_cycles;

  int errors = 0;
  int checks = 0;

  // Reference state, updated from frame outcomes only.
  int            exp_fc  = 0;
  logic [CW-1:0] exp_lc  = '0;
  int            exp_es  = 0;
  int            exp_cur = 0;

  layer_sequencer #(
    .NUM_STAGES    (NS),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_WIDTH     (CW),
    .IDX_W         (IW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .abort      (abort),
    .stage_start(stage_start),
    .stage_done (stage_done),
    .busy       (busy),
    .cur_stage  (cur_stage),
    .frame_done (frame_done),
    .error      (error),
    .err_stage  (err_stage),
    .frame_count(frame_count),
    .last_cycles(last_cycles)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Everything that must hold in an idle cycle, including the held registers.
  task automatic check_idle(input string tag);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_start"}, 32'(stage_start), 32'd0);
    check_output({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check_output({tag, "_error"}, 32'(error), 32'd0);
    check_output({tag, "_frame_count"}, 32'(frame_count), 32'(exp_fc[15:0]));
    check_output({tag, "_last_cycles"}, last_cycles, exp_lc);
    check_output({tag, "_err_stage"}, 32'(err_stage), 32'(exp_es));
    check_output({tag, "_cur_stage"}, 32'(cur_stage), 32'(exp_cur));
  endtask

  // Runs one frame starting from an idle falling edge, and returns at the falling
  // edge of the first idle cycle after it. An engine latency above TIMEOUT means
  // that engine never answers. abort_stage >= 0 asserts abort (or reset) in
  // WAIT cycle abort_w of that stage.
  task automatic apply_stimulus(input int l0, input int l1, input int l2,
                                input int abort_stage, input int abort_w,
                                input bit use_reset, input bit keep_start);
    int lat [NS];
    int fail_stage;
    int total;
    int limit;
    lat[0] = l0;
    lat[1] = l1;
    lat[2] = l2;
    fail_stage = -1;
    total = 0;
    for (int i = 0; i < NS; i++) begin
      if (fail_stage < 0) begin
        if (lat[i] > TIMEOUT) fail_stage = i;
        else total += 1 + lat[i];
      end
    end

    frame_start = 1'b1;
    stage_done  = NS'($urandom);
    abort       = 1'b0;
    step();
    for (int i = 0; i < NS; i++) begin
      check_output("launch_start", 32'(stage_start), 32'(1) << i);
      check_output("launch_busy", 32'(busy), 32'd1);
      check_output("launch_cur_stage", 32'(cur_stage), 32'(i));
      exp_cur     = i;
      frame_start = keep_start ? 1'b1 : 1'($urandom_range(0, 1));
      stage_done  = NS'($urandom);
      limit = (lat[i] > TIMEOUT) ? TIMEOUT : lat[i];
      for (int w = 1; w <= limit; w++) begin
        step();
        check_output("wait_start_low", 32'(stage_start), 32'd0);
        stage_done = NS'($urandom) & ~(NS'(1) << i);
        if (w == lat[i]) stage_done[i] = 1'b1;
        if (i == abort_stage && w == abort_w) begin
          if (use_reset) reset = 1'b1;
          else abort = 1'b1;
          step();
          if (use_reset) begin
            exp_fc  = 0;
            exp_lc  = '0;
            exp_es  = 0;
            exp_cur = 0;
          end
          check_idle(use_reset ? "reset_mid" : "abort_mid");
          reset       = 1'b0;
          abort       = 1'b0;
          frame_start = 1'b0;
          stage_done  = '0;
          step();
          check_idle(use_reset ? "reset_after" : "abort_after");
          return;
        end
      end
      step();
      if (i == fail_stage) begin
        check_output("timeout_error", 32'(error), 32'd1);
        check_output("timeout_err_stage", 32'(err_stage), 32'(i));
        check_output("timeout_frame_done", 32'(frame_done), 32'd0);
        check_output("timeout_start", 32'(stage_start), 32'd0);
        exp_es = i;
        break;
      end else if (i == NS - 1) begin
        check_output("frame_done", 32'(frame_done), 32'd1);
        check_output("done_error", 32'(error), 32'd0);
        check_output("done_last_cycles", last_cycles, 32'(total));
        check_output("done_busy", 32'(busy), 32'd1);
        exp_fc++;
        exp_lc = 32'(total);
      end
    end
    // The DONE/ERR cycle ignores abort and frame_start; both are driven at random here.
    abort       = 1'($urandom_range(0, 1));
    frame_start = keep_start ? 1'b1 : 1'($urandom_range(0, 1));
    stage_done  = NS'($urandom);
    step();
    check_idle("end_idle");
    abort       = 1'b0;
    stage_done  = '0;
    frame_start = keep_start;
  endtask

  initial begin
    int l [NS];
    int fs, ab_st, ab_w, gap;
    bit use_rst;

    $display("[TB] layer_sequencer bench starting");
    reset       = 1'b1;
    frame_start = 1'b0;
    abort       = 1'b0;
    stage_done  = '0;
    repeat (3) step();
    check_idle("reset");
    reset = 1'b0;
    step();
    check_idle("post_reset");

    // Nominal frame, kept back-to-back into a second identical frame.
    apply_stimulus(5, 1, 10, -1, 0, 1'b0, 1'b1);
    check_output("nominal_last_cycles", last_cycles, 32'd19);
    check_output("nominal_frame_count", 32'(frame_count), 32'd1);
    apply_stimulus(5, 1, 10, -1, 0, 1'b0, 1'b0);
    check_output("b2b_frame_count", 32'(frame_count), 32'd2);

    // Stage 1 never answers.
    apply_stimulus(3, 1000, 4, -1, 0, 1'b0, 1'b0);
    check_output("timeout_err_stage_held", 32'(err_stage), 32'd1);
    check_output("timeout_frame_count", 32'(frame_count), 32'd2);

    // Stage 1 answers on the last permitted WAIT cycle.
    apply_stimulus(2, TIMEOUT, 4, -1, 0, 1'b0, 1'b0);
    check_output("limit_frame_count", 32'(frame_count), 32'd3);

    // Abort, then reset, during the WAIT of stage 1.
    apply_stimulus(4, 15, 4, 1, 7, 1'b0, 1'b0);
    check_output("abort_frame_count", 32'(frame_count), 32'd3);
    apply_stimulus(4, 15, 4, 1, 7, 1'b1, 1'b0);
    check_output("reset_frame_count", 32'(frame_count), 32'd0);

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      fs = -1;
      for (int i = 0; i < NS; i++) begin
        l[i] = $urandom_range(1, TIMEOUT + 2);
        if (fs < 0 && l[i] > TIMEOUT) fs = i;
      end
      ab_st   = -1;
      ab_w    = 0;
      use_rst = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        ab_st = $urandom_range(0, NS - 1);
        if (fs >= 0 && ab_st > fs) ab_st = fs;
        ab_w    = $urandom_range(1, (l[ab_st] > TIMEOUT) ? TIMEOUT : l[ab_st]);
        use_rst = ($urandom_range(0, 3) == 0);
      end
      apply_stimulus(l[0], l[1], l[2], ab_st, ab_w, use_rst, 1'b0);
      gap = $urandom_range(0, 2);
      frame_start = 1'b0;
      for (int g = 0; g < gap; g++) begin
        step();
        check_output("gap_busy", 32'(busy), 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
Frame-level controller for the CNN inference chain. Launches each layer engine (conv, relu, maxpool, dense, …) in fixed order with a one-cycle start pulse and waits for that engine's one-cycle done pulse before launching the next. Provides frame handshake, abort, per-stage watchdog and frame cycle/frame counters for the top level and the host-facing status path.

Parameters:
NUM_STAGES, 4, number of sequenced layer engines; stage 0 runs first; must be >= 1
TIMEOUT_CYCLES, 65535, max WAIT cycles per stage before error; 0 disables the watchdog
CNT_WIDTH, 32, width of the cycle counter and the watchdog counter
IDX_W, $clog2(NUM_STAGES) (min 1), width of the stage index outputs

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
frame_start  in  1  request to run one frame; sampled only in IDLE
abort  in  1  cancel the frame in progress
stage_start  out  NUM_STAGES  one-hot start pulse to engine i
stage_done  in  NUM_STAGES  done pulse from engine i
busy  out  1  high in any state other than IDLE
cur_stage  out  IDX_W  index of the stage launched or awaited
frame_done  out  1  one-cycle pulse when the last stage completes
error  out  1  one-cycle pulse on watchdog expiry
err_stage  out  IDX_W  stage that timed out; held until the next error or reset
frame_count  out  16  frames completed successfully; wraps 0xFFFF->0
last_cycles  out  CNT_WIDTH  cycle count of the last successful frame

Behaviour:
- Reset: state IDLE; stage_start=0, busy=0, cur_stage=0, frame_done=0, error=0, err_stage=0, frame_count=0, last_cycles=0, internal counters 0.
- All outputs are registered and are a function of the current state plus the held registers. No combinational path from input to output.
- States:
  - IDLE: if frame_start=1, go to LAUNCH; idx=0; cycle counter=0.
  - LAUNCH: stage_start[idx]=1 for this one cycle only. Cycle counter increments. Watchdog clears. Go to WAIT.
  - WAIT: stage_start=0. Cycle counter and watchdog increment each cycle.
    - If stage_done[idx]=1 and idx<NUM_STAGES-1: idx++, go to LAUNCH.
    - If stage_done[idx]=1 and idx=NUM_STAGES-1: latch last_cycles = cycle counter + 1, go to DONE.
    - Otherwise, if TIMEOUT_CYCLES!=0 and the watchdog reaches TIMEOUT_CYCLES-1: latch err_stage=idx, go to ERR.
  - DONE: frame_done=1 for one cycle; frame_count++; go to IDLE.
  - ERR: error=1 for one cycle; go to IDLE. frame_count and last_cycles are unchanged.
- Latency:
  - frame_start sampled at edge k -> stage_start[0] high in cycle k+1.
  - stage_done[i] sampled at edge m -> stage_start[i+1] high in cycle m+1.
  - Final done at edge m -> frame_done high in cycle m+1; busy falls in cycle m+2.
- last_cycles counts LAUNCH and WAIT cycles of the frame. The counter saturates at all-ones.
- stage_done[j] with j!=idx is ignored in every state. stage_done is ignored outside WAIT.
- stage_done[idx] on the final watchdog cycle counts as success; done has priority over timeout.
- frame_start while busy (including DONE and ERR) is ignored, not queued.
- abort=1 in LAUNCH or WAIT: go to IDLE next edge. No frame_done, no error, counters unchanged. abort has priority over done and timeout. In IDLE, DONE or ERR, abort is ignored and the pulse still completes.
- cur_stage=idx in LAUNCH and WAIT; it holds its last value in IDLE, DONE and ERR.
- Reset mid-frame: next edge restores all reset values. Engines are reset by the same signal.

Test Plan:
- Nominal: NUM_STAGES=3, TIMEOUT=20; stub engines return done 5, 1 and 10 cycles after start. Pulse frame_start.
  - Required: stage_start = 001, 010, 100, each one cycle wide.
  - Required: frame_done 1 cycle after the stage-2 done; last_cycles=19; frame_count=1.
- Back-to-back: assert frame_start continuously for two frames.
  - Required: second stage_start[0] exactly 2 cycles after frame_done (ERR/DONE->IDLE->LAUNCH).
  - Required: frame_count=2.
- Timeout: stage 1 stub never responds, TIMEOUT=20.
  - Required: error pulse at WAIT cycle 20; err_stage=1; busy drops; frame_count unchanged; no stage_start[2].
- Done at limit: stage 1 done on WAIT cycle 20 exactly.
  - Required: no error; stage_start[2] follows.
- Spurious and ignored inputs:
  - stage_done[2] pulsed while waiting on stage 0 -> ignored.
  - frame_start mid-frame -> ignored.
  - Required: exactly 3 stage_start pulses per frame.
- Abort/reset: assert abort in WAIT of stage 1 -> IDLE next cycle, no frame_done or error.
  - Repeat with reset asserted instead -> all outputs return to reset values; frame_count=0.
